tape_player: RTL and testbench

//  Transmit side of the cassette path. Takes a byte stream (tape image bytes from the loader buffer)
//  and produces the Lynx 1-bit tape waveform on ear_out, which feeds the ear input of the machine/Audio.

---
 rtl/tape_player.sv | 150 +++++++++++++++
 tb/tb_tape_player.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tape_player.sv
// tape_player: Lynx 1-bit tape waveform generator (leader, sync, data MSB-first, trailer).
// Optional motor gating is enabled with the TAPE_PLAYER_MOTOR_EN macro.
module tape_player #(
    parameter int         HALF0       = 200,
    parameter int         HALF1       = 100,
    parameter int         LEADER_BITS = 768,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TRAIL_BITS  = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       start,
    input  logic [7:0] byte_data,
    input  logic       byte_last,
    input  logic       byte_valid,
`ifdef TAPE_PLAYER_MOTOR_EN
    input  logic       motor,
`endif
    output logic       byte_ready,
    output logic       ear_out,
    output logic       busy,
    output logic       done,
    output logic       underrun
);
    localparam int HMAX = (HALF0 > HALF1) ? HALF0 : HALF1;
    localparam int HW   = $clog2(HMAX + 1);
    localparam int BMAX = (LEADER_BITS > TRAIL_BITS) ? ((LEADER_BITS > 8) ? LEADER_BITS : 8)
                                                     : ((TRAIL_BITS > 8) ? TRAIL_BITS : 8);
    localparam int BW   = $clog2(BMAX + 1);

    typedef enum logic [2:0] {IDLE, LEADER, SYNC, DATA, TRAIL, DONE} state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   half_q, half_d;
    logic            low_q, low_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            full_q, full_d;
    logic            last_q, last_d;
    logic            underrun_q, underrun_d;
    logic            motor_on, active, sending, cur_bit, half_end, bit_end, byte_end, xfer;
    logic [HW-1:0]   half_lim;

`ifdef TAPE_PLAYER_MOTOR_EN
    assign motor_on = motor;
`else
    assign motor_on = 1'b1;
`endif

    // In DATA the engine only runs while the shifter holds a byte; otherwise it waits at a boundary.
    assign active     = state_q inside {LEADER, SYNC, DATA, TRAIL};
    assign sending    = active && (state_q != DATA || full_q);
    assign cur_bit    = (state_q == SYNC) ? SYNC_BYTE[3'd7 - bit_q[2:0]]
                      : (state_q == DATA) ? shift_q[7] : 1'b0;
    assign half_lim   = cur_bit ? HW'(HALF1 - 1) : HW'(HALF0 - 1);
    assign half_end   = half_q == half_lim;
    assign bit_end    = sending && low_q && half_end;
    assign byte_end   = bit_q == BW'(7);
    assign byte_ready = state_q == DATA && motor_on && !last_q && (!full_q || (bit_end && byte_end));
    assign xfer       = ce && byte_ready && byte_valid;
    assign ear_out    = sending && motor_on && !low_q;
    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
    assign underrun   = underrun_q;

    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        low_d      = low_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        full_d     = full_q;
        last_d     = last_q;
        underrun_d = underrun_q;
        if (ce) begin
            if (state_q == IDLE && start) begin
                state_d    = (LEADER_BITS == 0) ? SYNC : LEADER;
                half_d     = '0;
                low_d      = 1'b0;
                bit_d      = '0;
                full_d     = 1'b0;
                last_d     = 1'b0;
                underrun_d = 1'b0;
            end else if (state_q == DONE) begin
                state_d = IDLE;
            end else if (active && !motor_on) begin
                // restart the interrupted bit from its high half once the motor returns
                half_d = '0;
                low_d  = 1'b0;
            end else if (sending) begin
                half_d = half_end ? '0 : half_q + 1'b1;
                low_d  = low_q ^ half_end;
                if (bit_end) begin
                    bit_d = bit_q + 1'b1;
                    case (state_q)
                        LEADER: if (bit_q == BW'(LEADER_BITS - 1)) begin
                            state_d = SYNC;
                            bit_d   = '0;
                        end
                        SYNC: if (byte_end) begin
                            state_d = DATA;
                            bit_d   = '0;
                            full_d  = 1'b0;
                        end
                        DATA: begin
                            shift_d = {shift_q[6:0], 1'b0};
                            if (byte_end) begin
                                bit_d  = '0;
                                full_d = 1'b0;
                                if (last_q) state_d = (TRAIL_BITS == 0) ? DONE : TRAIL;
                            end
                        end
                        TRAIL: if (bit_q == BW'(TRAIL_BITS - 1)) state_d = DONE;
                        default: ;
                    endcase
                end
            end
            if (byte_ready && !byte_valid) underrun_d = 1'b1;
            if (xfer) begin
                shift_d = byte_data;
                last_d  = byte_last;
                full_d  = 1'b1;
                bit_d   = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            half_q     <= '0;
            low_q      <= 1'b0;
            bit_q      <= '0;
            shift_q    <= '0;
            full_q     <= 1'b0;
            last_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            low_q      <= low_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            full_q     <= full_d;
            last_q     <= last_d;
            underrun_q <= underrun_d;
        end
    end
endmodule

// File: tb/tb_tape_player.sv
// tb_tape_player: random-stimulus bench for tape_player against a per-tick waveform model.
module tb_tape_player;
    localparam int         H0 = 4, H1 = 2, LB = 2, TB = 1;
    localparam logic [7:0] SB = 8'hA5;

    logic       clock = 1'b0, reset = 1'b0, ce = 1'b1, start = 1'b0;
    logic       byte_last = 1'b0, byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_ready, ear_out, busy, done, underrun;
`ifdef TAPE_PLAYER_MOTOR_EN
    logic       motor = 1'b1;
`endif
    int n_checks = 0, n_fail = 0;

    typedef struct packed {logic ear, rdy, dn, bz, und; int bs;} exp_t;
    exp_t       ex[$];
    logic [7:0] q_bytes[$];
    int         q_gaps[$];
    logic       und_m;

    always #5 clock = ~clock;

    tape_player #(.HALF0(H0), .HALF1(H1), .LEADER_BITS(LB), .SYNC_BYTE(SB), .TRAIL_BITS(TB)) dut (
        .clock(clock), .reset(reset), .ce(ce), .start(start),
        .byte_data(byte_data), .byte_last(byte_last), .byte_valid(byte_valid),
`ifdef TAPE_PLAYER_MOTOR_EN
        .motor(motor),
`endif
        .byte_ready(byte_ready), .ear_out(ear_out), .busy(busy), .done(done), .underrun(underrun)
    );

    function automatic void push(logic e, logic r, logic d, logic b, int s);
        ex.push_back('{e, r, d, b, und_m, s});
    endfunction

    function automatic void push_bit(logic v);
        int h = v ? H1 : H0;
        int s = ex.size();
        for (int i = 0; i < 2 * h; i++) push(i < h, 1'b0, 1'b0, 1'b1, s);
    endfunction

    // Expected per-tick outputs from the tick after start through the first IDLE tick.
    function automatic void build();
        logic [7:0] v;
        logic [7:0] sb = SB;
        ex = {};
        und_m = 1'b0;
        for (int i = 0; i < LB; i++) push_bit(1'b0);
        for (int i = 7; i >= 0; i--) push_bit(sb[i]);
        for (int k = 0; k < q_bytes.size(); k++) begin
            if (k == 0) push(1'b0, 1'b1, 1'b0, 1'b1, -1);
            else ex[ex.size() - 1].rdy = 1'b1;
            if (q_gaps[k] > 0) begin
                und_m = 1'b1;
                for (int g = 0; g < q_gaps[k]; g++) push(1'b0, 1'b1, 1'b0, 1'b1, -1);
            end
            v = q_bytes[k];
            for (int i = 7; i >= 0; i--) push_bit(v[i]);
        end
        for (int i = 0; i < TB; i++) push_bit(1'b0);
        push(1'b0, 1'b0, 1'b1, 1'b1, -1);
        push(1'b0, 1'b0, 1'b0, 1'b0, -1);
    endfunction

    // Motor off for 5 ticks at d: silent gap, then the interrupted bit replays from its start.
    function automatic void splice(int d);
        exp_t t[$];
        int s = ex[d].bs;
        t = ex;
        ex = {};
        for (int i = 0; i < d; i++) ex.push_back(t[i]);
        for (int i = 0; i < 5; i++) ex.push_back('{1'b0, 1'b0, 1'b0, 1'b1, t[d].und, -1});
        for (int i = s; i < t.size(); i++) ex.push_back(t[i]);
    endfunction

    task automatic run_block(input logic noise, input int drop_at);
        int idx = 0, xf = 0, gl, d = -1;
        int n = q_bytes.size();
        build();
        if (drop_at >= 0) begin
            d = drop_at;
            while (d < ex.size() - 3 && ex[d].bs < 0) d++;
            splice(d);
        end
        gl = q_gaps[0];
        @(posedge clock);
        #1 start = 1'b1;
        byte_valid = 1'b1;
        byte_data  = q_bytes[0];
        byte_last  = (n == 1);
        @(posedge clock);
        for (int t = 0; t < ex.size(); t++) begin
            #1 start = noise && t < ex.size() - 1 && $urandom_range(0, 2) == 0;
`ifdef TAPE_PLAYER_MOTOR_EN
            motor = !(d >= 0 && t >= d && t < d + 5);
`endif
            #1;
            if (idx < n) begin
                if (byte_ready && gl > 0) begin
                    byte_valid = 1'b0;
                    gl--;
                end else begin
                    byte_valid = 1'b1;
                    byte_data  = q_bytes[idx];
                    byte_last  = (idx == n - 1);
                end
            end else byte_valid = 1'b0;
            @(negedge clock);
            n_checks += 5;
            if (ear_out !== ex[t].ear) begin n_fail++; $display("FAIL ear_out tick %0d: got %b expected %b", t, ear_out, ex[t].ear); end
            if (byte_ready !== ex[t].rdy) begin n_fail++; $display("FAIL byte_ready tick %0d: got %b expected %b", t, byte_ready, ex[t].rdy); end
            if (done !== ex[t].dn) begin n_fail++; $display("FAIL done tick %0d: got %b expected %b", t, done, ex[t].dn); end
            if (busy !== ex[t].bz) begin n_fail++; $display("FAIL busy tick %0d: got %b expected %b", t, busy, ex[t].bz); end
            if (underrun !== ex[t].und) begin n_fail++; $display("FAIL underrun tick %0d: got %b expected %b", t, underrun, ex[t].und); end
            if (byte_ready && byte_valid) begin
                xf++;
                idx++;
                gl = (idx < n) ? q_gaps[idx] : 0;
            end
            @(posedge clock);
        end
        #1 start = 1'b0;
        byte_valid = 1'b0;
`ifdef TAPE_PLAYER_MOTOR_EN
        motor = 1'b1;
`endif
        n_checks++;
        if (xf != n) begin n_fail++; $display("FAIL transfers: got %0d expected %0d", xf, n); end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        @(negedge clock);
        n_checks += 5;
        if (ear_out !== 1'b0) begin n_fail++; $display("FAIL reset ear_out: got %b expected 0", ear_out); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
        if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset byte_ready: got %b expected 0", byte_ready); end
        if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset underrun: got %b expected 0", underrun); end
    endtask

    task automatic test_stream();
        q_bytes = {8'h80, 8'h01};
        q_gaps  = {0, 0};
        run_block(1'b0, -1);
    endtask

    task automatic test_underrun();
        q_bytes = {8'($urandom), 8'($urandom)};
        q_gaps  = {3, 10};
        run_block(1'b0, -1);
        @(negedge clock);
        n_checks++;
        if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun sticky: got %b expected 1", underrun); end
        q_bytes = {8'($urandom)};
        q_gaps  = {0};
        run_block(1'b0, -1);
    endtask

    task automatic test_random(input logic noise, input int runs);
        for (int r = 0; r < runs; r++) begin
            int n = $urandom_range(1, 4);
            q_bytes = {};
            q_gaps  = {};
            for (int k = 0; k < n; k++) begin
                q_bytes.push_back(8'($urandom));
                q_gaps.push_back(($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0);
            end
            run_block(noise, -1);
        end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        @(posedge clock);
        #1 start = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h5C;
        byte_last  = 1'b0;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        while (!(byte_ready && byte_valid) && c < 300) begin
            @(negedge clock);
            c++;
        end
        n_checks++;
        if (c >= 300) begin
            n_fail++;
            $display("FAIL reset_mid: no transfer within 300 cycles");
        end
        @(posedge clock);
        #2;
        n_checks++;
        if (ear_out !== 1'b1) begin n_fail++; $display("FAIL reset_mid bit start ear_out: got %b expected 1", ear_out); end
        reset = 1'b0;
        #1;
        n_checks += 4;
        if (ear_out !== 1'b0) begin n_fail++; $display("FAIL reset_mid ear_out: got %b expected 0", ear_out); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid busy: got %b expected 0", busy); end
        if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mid byte_ready: got %b expected 0", byte_ready); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_mid done: got %b expected 0", done); end
        byte_valid = 1'b0;
        @(negedge clock) reset = 1'b1;
        q_bytes = {8'($urandom), 8'($urandom)};
        q_gaps  = {0, 0};
        run_block(1'b0, -1);
    endtask

    task automatic test_motor();
        for (int r = 0; r < 4; r++) begin
            q_bytes = {8'($urandom), 8'($urandom)};
            q_gaps  = {0, 0};
            run_block(1'b0, $urandom_range(3, 150));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_underrun();
        test_random(1'b1, 2);
        test_random(1'b0, 4);
        test_reset_mid();
`ifdef TAPE_PLAYER_MOTOR_EN
        test_motor();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
